pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing stage of the CPU datapath.
- Sits directly downstream of the branch-target lookup table: consumes its D-bit target and the decoder's jump enables, and produces the instruction-memory address.
- Adds run control: a start/done handshake with the testbench or top level, stall, halt, and a saturating cycle counter.

---
 rtl/pc_fetch_ctrl.sv | 93 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch sequencer: IDLE/RUN/DONE run control, jump
// selection and a saturating RUN-cycle counter. All outputs are registered.
module pc_fetch_ctrl #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic [D-1:0]  target,
    input  logic          reljump_en,
    input  logic          absjump_en,
    input  logic          stall,
    input  logic          halt,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_count,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    // Control inputs are read only in the RUN arm, so X on them while
    // idle or done can never reach the registers.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_addr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (halt) begin
                    state_d = DONE;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (absjump_en) begin
                    pc_d = target;
                end else if (reljump_en) begin
                    pc_d = pc_q + target;
                end else begin
                    pc_d = pc_q + {{(D-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign prog_ctr    = pc_q;
    assign running     = running_q;
    assign done        = done_q;
    assign cycle_count = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a behavioural model (a 16-bit and a 4-bit counter build).
module tb_pc_fetch_ctrl;

    localparam int D = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [D-1:0]  start_addr = '0;
    logic [D-1:0]  target = '0;
    logic          reljump_en = 1'b0;
    logic          absjump_en = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;

    logic [D-1:0]  prog_ctr, prog_ctr4;
    logic          running, running4, done, done4;
    logic [15:0]   cycle_count;
    logic [3:0]    cycle_count4;
    logic [1:0]    state_dbg, state_dbg4;

    pc_fetch_ctrl #(.D(D), .CW(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .target(target), .reljump_en(reljump_en), .absjump_en(absjump_en),
        .stall(stall), .halt(halt), .prog_ctr(prog_ctr), .running(running),
        .done(done), .cycle_count(cycle_count), .state_dbg(state_dbg)
    );

    pc_fetch_ctrl #(.D(D), .CW(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .target(target), .reljump_en(reljump_en), .absjump_en(absjump_en),
        .stall(stall), .halt(halt), .prog_ctr(prog_ctr4), .running(running4),
        .done(done4), .cycle_count(cycle_count4), .state_dbg(state_dbg4)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: "idle", "run", "done" as plain strings
    string m_mode = "idle";
    int    m_pc   = 0;
    int    m_cnt  = 0;
    int    m_cnt4 = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = "idle";
        m_pc   = 0;
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    task automatic model_step();
        if (m_mode == "run") begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            if (halt === 1'b1)            m_mode = "done";
            else if (stall === 1'b1)      m_pc = m_pc;
            else if (absjump_en === 1'b1) m_pc = int'(target);
            else if (reljump_en === 1'b1) m_pc = (m_pc + int'(target)) % 4096;
            else                          m_pc = (m_pc + 1) % 4096;
        end else if (start === 1'b1) begin
            m_mode = "run";
            m_pc   = int'(start_addr);
            m_cnt  = 0;
            m_cnt4 = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".pc"},      32'(prog_ctr),     32'(m_pc));
        check_eq({tag, ".running"}, 32'(running),      32'(m_mode == "run"));
        check_eq({tag, ".done"},    32'(done),         32'(m_mode == "done"));
        check_eq({tag, ".count"},   32'(cycle_count),  32'(m_cnt));
        check_eq({tag, ".count4"},  32'(cycle_count4), 32'(m_cnt4));
        check_eq({tag, ".pc4"},     32'(prog_ctr4),    32'(m_pc));
        check_eq({tag, ".done4"},   32'(done4),        32'(m_mode == "done"));
    endtask

    // driver
    task automatic drive(input logic st, input int sa, input int tg,
                         input logic rel, input logic abs_, input logic stl, input logic hlt);
        start      = st;
        start_addr = D'(sa);
        target     = D'(tg);
        reljump_en = rel;
        absjump_en = abs_;
        stall      = stl;
        halt       = hlt;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic launch(input int sa, input string tag);
        drive(1'b1, sa, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(tag);
        start = 1'b0;
    endtask

    int frozen;

    initial begin
        // reset state
        #12;
        model_reset();
        compare_all("reset");
        reset_n = 1'b1;

        // X on control inputs while idle must not disturb anything
        reljump_en = 1'bx; absjump_en = 1'bx; stall = 1'bx; halt = 1'bx; target = 'x;
        step("idle_x");
        step("idle_x");
        check_eq("idle_x_pc", 32'(prog_ctr), 32'd0);

        // 1: async reset mid-run, then count from 0
        launch(37, "tp1_launch");
        check_eq("tp1_pc37", 32'(prog_ctr), 32'd37);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("tp1_async");
        check_eq("tp1_async_pc", 32'(prog_ctr), 32'd0);
        check_eq("tp1_async_run", 32'(running), 32'd0);
        #2 reset_n = 1'b1;
        launch(0, "tp1_relaunch");
        for (int i = 1; i <= 3; i++) begin
            step("tp1_count");
            check_eq("tp1_seq", 32'(prog_ctr), 32'(i));
        end

        // 2: relative jumps and wrap
        drive(1'b0, 0, 4, 1'b0, 1'b1, 1'b0, 1'b0); step("tp2_to4");
        drive(1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0); step("tp2_rel3");
        check_eq("tp2_pc7", 32'(prog_ctr), 32'd7);
        drive(1'b0, 0, 4095, 1'b1, 1'b0, 1'b0, 1'b0); step("tp2_relm1");
        check_eq("tp2_pc6", 32'(prog_ctr), 32'd6);
        drive(1'b0, 0, 4095, 1'b0, 1'b1, 1'b0, 1'b0); step("tp2_to4095");
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); step("tp2_wrap");
        check_eq("tp2_pc0", 32'(prog_ctr), 32'd0);

        // 3: absolute beats relative; stall beats absolute
        drive(1'b0, 0, 10, 1'b0, 1'b1, 1'b0, 1'b0); step("tp3_to10");
        drive(1'b0, 0, 68, 1'b1, 1'b1, 1'b0, 1'b0); step("tp3_both");
        check_eq("tp3_pc68", 32'(prog_ctr), 32'd68);
        drive(1'b0, 0, 12, 1'b0, 1'b1, 1'b1, 1'b0); step("tp3_stall");
        check_eq("tp3_hold68", 32'(prog_ctr), 32'd68);

        // 4: halt wins, DONE ignores controls, relaunch
        drive(1'b0, 0, 20, 1'b0, 1'b1, 1'b0, 1'b0); step("tp4_to20");
        drive(1'b0, 0, 5, 1'b0, 1'b1, 1'b0, 1'b1); step("tp4_halt");
        check_eq("tp4_pc20", 32'(prog_ctr), 32'd20);
        check_eq("tp4_done", 32'(done), 32'd1);
        frozen = int'(cycle_count);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, $urandom_range(0, 4095), 1'(i), 1'(i + 1), 1'(i >> 1), 1'(i));
            step("tp4_ignore");
        end
        check_eq("tp4_frozen", 32'(cycle_count), 32'(frozen));
        launch(16, "tp4_relaunch");
        check_eq("tp4_pc16", 32'(prog_ctr), 32'd16);
        check_eq("tp4_cnt0", 32'(cycle_count), 32'd0);

        // 5: 4-bit counter saturation; start while running is ignored
        drive(1'b1, 999, 0, 1'b0, 1'b0, 1'b0, 1'b0); step("tp5_start_in_run");
        start = 1'b0;
        for (int i = 0; i < 19; i++) step("tp5_run");
        check_eq("tp5_cnt4", 32'(cycle_count4), 32'd15);
        check_eq("tp5_cnt16", 32'(cycle_count), 32'd20);
        halt = 1'b1; step("tp5_halt");
        halt = 1'b0;
        check_eq("tp5_done4", 32'(done4), 32'd1);
        check_eq("tp5_cnt4_hold", 32'(cycle_count4), 32'd15);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            int sa;
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095);
            drive(1'($urandom_range(0, 9) == 0), sa, $urandom_range(0, 4095),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                model_reset();
                compare_all("rnd_async");
                #1 reset_n = 1'b1;
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
